// File: rtl/ulpi_reg_ctl.sv
// ulpi_reg_ctl: link-side ULPI register access engine plus RX CMD decoder.
//   clk/rst         60 MHz ULPI clock, synchronous active-high reset
//   ulpi_*          ULPI bus (dir/nxt/data_in from PHY; data_out/oe/stp to PHY)
//   reg_en/we/addr/din  single-register request from the state controller
//   reg_dout/rdy/err    completion pulse, read data, timeout qualifier
//   line_state/vbus_state  fields of the last decoded RX CMD byte
// Register accesses use immediate addressing only (0x00-0x3F); an access that
// loses the bus to the PHY is abandoned silently and retried once dir has been
// low for two cycles.
module ulpi_reg_ctl #(
  parameter int NXT_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  input  logic [7:0] ulpi_data_in,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_data_oe,
  output logic       ulpi_stp,
  input  logic       reg_en,
  input  logic       reg_we,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_din,
  output logic [7:0] reg_dout,
  output logic       reg_rdy,
  output logic       reg_err,
  output logic [1:0] line_state,
  output logic [1:0] vbus_state
);

  localparam int CW = $clog2(NXT_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(NXT_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_STP, S_RTURN, S_RDATA} state_t;

  state_t        state, state_nx;
  logic          dir_q, pend, we_q, tflag;
  logic [5:0]    addr_q;
  logic [7:0]    din_q;
  logic [CW-1:0] cnt;

  logic [7:0] data_nx, dout_nx;
  logic       stp_nx, rdy_nx, err_nx, pend_clr, tflag_nx;
  logic       start, to_hit, rx_dec;
  logic       unused_addr;

  assign unused_addr  = ^reg_addr[7:6];
  assign ulpi_data_oe = ~ulpi_dir;
  // Bus is free only after dir has been low this cycle and the previous one.
  assign start  = pend && !ulpi_dir && !dir_q;
  // Counter value TO_LAST on the edge being evaluated means NXT_TIMEOUT cycles
  // have been spent in the state without nxt.
  assign to_hit = (cnt == TO_LAST);
  // RX CMD: PHY owns the bus past turnaround, no nxt, and not our read data.
  assign rx_dec = ulpi_dir && dir_q && !ulpi_nxt && (state != S_RDATA);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      dir_q         <= 1'b0;
      pend          <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      din_q         <= '0;
      tflag         <= 1'b0;
      cnt           <= '0;
      ulpi_data_out <= 8'h00;
      ulpi_stp      <= 1'b0;
      reg_dout      <= 8'h00;
      reg_rdy       <= 1'b0;
      reg_err       <= 1'b0;
      line_state    <= 2'b00;
      vbus_state    <= 2'b00;
    end else begin
      state         <= state_nx;
      dir_q         <= ulpi_dir;
      tflag         <= tflag_nx;
      ulpi_data_out <= data_nx;
      ulpi_stp      <= stp_nx;
      reg_dout      <= dout_nx;
      reg_rdy       <= rdy_nx;
      reg_err       <= err_nx;
      if (pend_clr)
        pend <= 1'b0;
      else if (reg_en && !pend && state == S_IDLE) begin
        pend   <= 1'b1;
        we_q   <= reg_we;
        addr_q <= reg_addr[5:0];
        din_q  <= reg_din;
      end
      if (state_nx != state || (state != S_CMD && state != S_WDATA))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (rx_dec) begin
        line_state <= ulpi_data_in[1:0];
        vbus_state <= ulpi_data_in[3:2];
      end
    end
  end

  // Next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_CMD;
      S_CMD: begin
        if (ulpi_dir)      state_nx = S_IDLE;
        else if (ulpi_nxt) state_nx = we_q ? S_WDATA : S_RTURN;
        else if (to_hit)   state_nx = S_STP;
      end
      S_WDATA: begin
        if (ulpi_dir)      state_nx = S_IDLE;
        else if (ulpi_nxt) state_nx = S_STP;
        else if (to_hit)   state_nx = S_STP;
      end
      S_STP:   state_nx = S_IDLE;
      S_RTURN: state_nx = ulpi_dir ? S_RDATA : S_IDLE;
      S_RDATA: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    data_nx  = ulpi_data_out;
    dout_nx  = reg_dout;
    stp_nx   = 1'b0;
    rdy_nx   = 1'b0;
    err_nx   = 1'b0;
    pend_clr = 1'b0;
    tflag_nx = tflag;
    case (state)
      S_IDLE: if (start) data_nx = {(we_q ? 2'b10 : 2'b11), addr_q};
      S_CMD: begin
        if (ulpi_dir)      data_nx = 8'h00;
        else if (ulpi_nxt) data_nx = we_q ? din_q : 8'h00;
        else if (to_hit) begin
          data_nx  = 8'h00;
          stp_nx   = 1'b1;
          tflag_nx = 1'b1;
        end
      end
      S_WDATA: begin
        if (ulpi_dir) data_nx = 8'h00;
        else if (ulpi_nxt) begin
          data_nx = 8'h00;
          stp_nx  = 1'b1;
        end else if (to_hit) begin
          data_nx  = 8'h00;
          stp_nx   = 1'b1;
          tflag_nx = 1'b1;
        end
      end
      S_STP: begin
        rdy_nx   = 1'b1;
        err_nx   = tflag;
        pend_clr = 1'b1;
        tflag_nx = 1'b0;
      end
      S_RTURN: if (!ulpi_dir) data_nx = 8'h00;
      S_RDATA: begin
        if (ulpi_dir && !ulpi_nxt) begin
          dout_nx  = ulpi_data_in;
          rdy_nx   = 1'b1;
          pend_clr = 1'b1;
        end else
          data_nx = 8'h00;
      end
      default: data_nx = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_ulpi_reg_ctl.sv
// Directed bench for ulpi_reg_ctl: a scripted PHY drives dir/nxt/data cycle
// by cycle; outputs are sampled 1 ns after each rising edge.
module tb_ulpi_reg_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ulpi_dir = 1'b0, ulpi_nxt = 1'b0;
  logic [7:0] ulpi_data_in = 8'h00;
  logic [7:0] ulpi_data_out;
  logic       ulpi_data_oe, ulpi_stp;
  logic       reg_en = 1'b0, reg_we = 1'b0;
  logic [7:0] reg_addr = 8'h00, reg_din = 8'h00;
  logic [7:0] reg_dout;
  logic       reg_rdy, reg_err;
  logic [1:0] line_state, vbus_state;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ulpi_reg_ctl #(.NXT_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt), .ulpi_data_in(ulpi_data_in),
    .ulpi_data_out(ulpi_data_out), .ulpi_data_oe(ulpi_data_oe), .ulpi_stp(ulpi_stp),
    .reg_en(reg_en), .reg_we(reg_we), .reg_addr(reg_addr), .reg_din(reg_din),
    .reg_dout(reg_dout), .reg_rdy(reg_rdy), .reg_err(reg_err),
    .line_state(line_state), .vbus_state(vbus_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a request; returns after the edge that samples reg_en.
  task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] din);
    reg_en = 1'b1; reg_we = we; reg_addr = addr; reg_din = din;
    step();
    reg_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    nvec++; if (ulpi_data_out !== 8'h00) begin nerr++; $display("FAIL reset_data got=%h exp=00", ulpi_data_out); end
    nvec++; if ({ulpi_stp, reg_rdy, reg_err} !== 3'b000) begin nerr++; $display("FAIL reset_flags got=%b exp=000", {ulpi_stp, reg_rdy, reg_err}); end
    nvec++; if ({reg_dout, line_state, vbus_state} !== 12'h000) begin nerr++; $display("FAIL reset_regs got=%h exp=000", {reg_dout, line_state, vbus_state}); end
    nvec++; if (ulpi_data_oe !== 1'b1) begin nerr++; $display("FAIL reset_oe got=%b exp=1", ulpi_data_oe); end
  endtask

  task automatic test_write();
    issue(1'b1, 8'h0A, 8'h00);                // edge0
    nvec++; if (ulpi_data_out !== 8'h00) begin nerr++; $display("FAIL wr_pre got=%h exp=00", ulpi_data_out); end
    step();                                   // edge1: CMD on bus
    nvec++; if (ulpi_data_out !== 8'h8A) begin nerr++; $display("FAIL wr_cmd got=%h exp=8a", ulpi_data_out); end
    step();                                   // edge2: no nxt yet, hold
    nvec++; if (ulpi_data_out !== 8'h8A) begin nerr++; $display("FAIL wr_hold got=%h exp=8a", ulpi_data_out); end
    ulpi_nxt = 1'b1;
    step();                                   // edge3: data phase
    nvec++; if (ulpi_data_out !== 8'h00 || ulpi_stp !== 1'b0) begin nerr++; $display("FAIL wr_data got=%h/%b exp=00/0", ulpi_data_out, ulpi_stp); end
    step();                                   // edge4: stp
    ulpi_nxt = 1'b0;
    nvec++; if (ulpi_stp !== 1'b1 || ulpi_data_out !== 8'h00 || reg_rdy !== 1'b0) begin nerr++; $display("FAIL wr_stp got=%b/%h/%b exp=1/00/0", ulpi_stp, ulpi_data_out, reg_rdy); end
    step();                                   // edge5: completion
    nvec++; if ({reg_rdy, reg_err, ulpi_stp} !== 3'b100) begin nerr++; $display("FAIL wr_rdy got=%b exp=100", {reg_rdy, reg_err, ulpi_stp}); end
    step();
    nvec++; if ({reg_rdy, reg_err} !== 2'b00) begin nerr++; $display("FAIL wr_rdy_pulse got=%b exp=00", {reg_rdy, reg_err}); end
  endtask

  task automatic test_read();
    issue(1'b0, 8'h04, 8'h00);
    step();
    nvec++; if (ulpi_data_out !== 8'hC4) begin nerr++; $display("FAIL rd_cmd got=%h exp=c4", ulpi_data_out); end
    ulpi_nxt = 1'b1;
    step();                                   // RTURN
    nvec++; if (ulpi_data_out !== 8'h00) begin nerr++; $display("FAIL rd_idle_bus got=%h exp=00", ulpi_data_out); end
    ulpi_nxt = 1'b0; ulpi_dir = 1'b1; ulpi_data_in = 8'h0D;
    #1;
    nvec++; if (ulpi_data_oe !== 1'b0) begin nerr++; $display("FAIL rd_oe got=%b exp=0", ulpi_data_oe); end
    step();                                   // RDATA
    ulpi_data_in = 8'h45;
    step();
    ulpi_dir = 1'b0; ulpi_data_in = 8'h00;
    nvec++; if (reg_rdy !== 1'b1 || reg_dout !== 8'h45 || reg_err !== 1'b0) begin nerr++; $display("FAIL rd_data got=%b/%h/%b exp=1/45/0", reg_rdy, reg_dout, reg_err); end
    nvec++; if ({line_state, vbus_state} !== 4'b0000) begin nerr++; $display("FAIL rd_line got=%b exp=0000", {line_state, vbus_state}); end
    step();
    nvec++; if (reg_rdy !== 1'b0) begin nerr++; $display("FAIL rd_rdy_pulse got=%b exp=0", reg_rdy); end
    step();
  endtask

  task automatic test_rxcmd();
    ulpi_dir = 1'b1; ulpi_data_in = 8'h0D;
    step();                                   // turnaround byte ignored
    nvec++; if ({line_state, vbus_state} !== 4'b0000) begin nerr++; $display("FAIL rx_turn got=%b exp=0000", {line_state, vbus_state}); end
    step();
    nvec++; if (line_state !== 2'b01 || vbus_state !== 2'b11) begin nerr++; $display("FAIL rx_decode got=%b/%b exp=01/11", line_state, vbus_state); end
    ulpi_nxt = 1'b1; ulpi_data_in = 8'h02;
    step();                                   // nxt=1 byte is data, not RX CMD
    nvec++; if (line_state !== 2'b01 || vbus_state !== 2'b11) begin nerr++; $display("FAIL rx_nxt got=%b/%b exp=01/11", line_state, vbus_state); end
    ulpi_nxt = 1'b0; ulpi_dir = 1'b0; ulpi_data_in = 8'h0E;
    step();                                   // turnaround back
    nvec++; if (line_state !== 2'b01 || vbus_state !== 2'b11) begin nerr++; $display("FAIL rx_turn_back got=%b/%b exp=01/11", line_state, vbus_state); end
    ulpi_data_in = 8'h00;
    step();
  endtask

  task automatic test_abort_retry();
    issue(1'b1, 8'h04, 8'h45);
    step();
    nvec++; if (ulpi_data_out !== 8'h84) begin nerr++; $display("FAIL ab_cmd got=%h exp=84", ulpi_data_out); end
    ulpi_dir = 1'b1; ulpi_data_in = 8'h00; ulpi_nxt = 1'b1;
    #1;
    nvec++; if (ulpi_data_oe !== 1'b0) begin nerr++; $display("FAIL ab_oe got=%b exp=0", ulpi_data_oe); end
    step();
    ulpi_nxt = 1'b0;
    nvec++; if (ulpi_data_out !== 8'h00 || reg_rdy !== 1'b0) begin nerr++; $display("FAIL ab_abort got=%h/%b exp=00/0", ulpi_data_out, reg_rdy); end
    step();
    ulpi_dir = 1'b0;
    step();                                   // dir low one cycle: not yet
    nvec++; if (ulpi_data_out !== 8'h00 || reg_rdy !== 1'b0) begin nerr++; $display("FAIL ab_wait got=%h/%b exp=00/0", ulpi_data_out, reg_rdy); end
    step();
    nvec++; if (ulpi_data_out !== 8'h84) begin nerr++; $display("FAIL ab_retry got=%h exp=84", ulpi_data_out); end
    ulpi_nxt = 1'b1;
    step();
    nvec++; if (ulpi_data_out !== 8'h45) begin nerr++; $display("FAIL ab_data got=%h exp=45", ulpi_data_out); end
    step();
    ulpi_nxt = 1'b0;
    nvec++; if (ulpi_stp !== 1'b1) begin nerr++; $display("FAIL ab_stp got=%b exp=1", ulpi_stp); end
    step();
    nvec++; if ({reg_rdy, reg_err} !== 2'b10) begin nerr++; $display("FAIL ab_rdy got=%b exp=10", {reg_rdy, reg_err}); end
    step();
  endtask

  task automatic test_timeout();
    int n;
    bit early;
    n = 0; early = 1'b0;
    issue(1'b1, 8'hD0, 8'h33);               // addr[7:6] must be ignored
    step();
    nvec++; if (ulpi_data_out !== 8'h90) begin nerr++; $display("FAIL to_cmd got=%h exp=90", ulpi_data_out); end
    while (ulpi_stp !== 1'b1 && n < 400) begin
      step();
      n++;
      if (reg_rdy === 1'b1) early = 1'b1;
    end
    nvec++; if (n !== 255) begin nerr++; $display("FAIL to_cycles got=%0d exp=255", n); end
    nvec++; if (early !== 1'b0 || ulpi_data_out !== 8'h00) begin nerr++; $display("FAIL to_stp_state got=%b/%h exp=0/00", early, ulpi_data_out); end
    step();
    nvec++; if ({reg_rdy, reg_err, ulpi_stp} !== 3'b110) begin nerr++; $display("FAIL to_err got=%b exp=110", {reg_rdy, reg_err, ulpi_stp}); end
    nvec++; if (reg_dout !== 8'h45) begin nerr++; $display("FAIL to_dout got=%h exp=45", reg_dout); end
    step();
    nvec++; if ({reg_rdy, reg_err} !== 2'b00) begin nerr++; $display("FAIL to_clear got=%b exp=00", {reg_rdy, reg_err}); end
  endtask

  task automatic test_reset_mid();
    bit bad;
    bad = 1'b0;
    issue(1'b1, 8'h05, 8'h77);
    step();
    ulpi_nxt = 1'b1;
    step();
    ulpi_nxt = 1'b0;
    nvec++; if (ulpi_data_out !== 8'h77) begin nerr++; $display("FAIL rm_data got=%h exp=77", ulpi_data_out); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    nvec++; if ({ulpi_data_out, ulpi_stp, reg_rdy} !== 10'h000) begin nerr++; $display("FAIL rm_reset got=%h exp=000", {ulpi_data_out, ulpi_stp, reg_rdy}); end
    nvec++; if ({reg_dout, line_state, vbus_state} !== 12'h000) begin nerr++; $display("FAIL rm_regs got=%h exp=000", {reg_dout, line_state, vbus_state}); end
    for (int i = 0; i < 6; i++) begin
      step();
      if (ulpi_data_out !== 8'h00 || ulpi_stp !== 1'b0 || reg_rdy !== 1'b0) bad = 1'b1;
    end
    nvec++; if (bad !== 1'b0) begin nerr++; $display("FAIL rm_no_retry got=%b exp=0", bad); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_rxcmd();
    test_abort_retry();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
